delay_sched: RTL and testbench
==============================

# delay_sched

Round-robin scheduler that shares one programmable delay counter among NREQ requesters. Each requester asks for a delay of its own length; the block grants the counter to one requester at a time, counts the latched length, then returns a one-cycle done pulse to the owner. It sits in front of the long-interval timing logic (N on the order of 400000 cycles) so several consumers reuse a single CBITS-wide counter instead of instantiating one each.

## Interface
- NREQ, 4, number of requesters (2..8)
- CBITS, 19, counter and length width
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req  in  NREQ  per-requester request level; held until done or abort
- len  in  NREQ*CBITS  per-requester delay length; slice i = len[i*CBITS +: CBITS]
- gnt  out  NREQ  one-hot owner of the counter; all-zero when idle
- done  out  NREQ  one-cycle pulse to owner when its delay has elapsed
- busy  out  1  counter owned (equals |gnt)
- err  out  1  sticky internal-consistency error (see Configuration)

## Operation
- States: IDLE, COUNT. All outputs registered.
- Reset: state=IDLE, gnt=0, done=0, busy=0, err=0, cnt=0, lim=0, rr pointer ptr=0.
- IDLE: eligible = req & ~done (a requester whose done is high this cycle is masked). If eligible≠0, winner = first set bit searching ptr, ptr+1, … mod NREQ. At the edge: gnt=onehot(winner), busy=1, cnt=0, lim=len slice of winner, ptr=(winner+1) mod NREQ, state=COUNT. Otherwise hold.
- COUNT, owner i:
  - req[i]=0 (abort): gnt=0, busy=0, no done, state=IDLE; ptr unchanged from grant.
  - else cnt==lim: done[i]=1, gnt=0, busy=0, state=IDLE.
  - else cnt=cnt+1.
- done is high for exactly one cycle; it is cleared at the next edge in all cases.
- len is latched only at grant; changes to any len slice during COUNT have no effect.
- Requests from non-owners during COUNT are held and arbitrated in the next IDLE cycle; none are lost.
- Arithmetic: cnt, lim unsigned CBITS; cnt never exceeds lim, so no wrap. lim=0 legal; lim=2^CBITS-1 legal.

## Timing
- Request sampled at edge E0 in IDLE → gnt/busy high after E0.
- Done pulse high in the cycle after edge E0+lim+1, i.e. gnt is high for lim+1 cycles, then done for 1 cycle with gnt=0.
- lim=0: gnt for 1 cycle, then done.
- Back-to-back: the done cycle is an IDLE cycle; the next grant is visible after edge E0+lim+2 (one dead cycle between grants).
- Abort: req[i] low before edge Ek in COUNT → gnt=0 after Ek; done never fires for that grant.
- rst has priority over everything and takes effect at the next edge mid-operation; a pending done is dropped.

## Configuration
- DELAY_SCHED_CHK_EN defined: err is set at the next edge, and stays set until rst, if any of the following holds:
  - cnt>lim in COUNT;
  - gnt is not one-hot-or-zero;
  - busy≠|gnt;
  - done has more than one bit set.
- Not defined: checker logic absent; err tied to 0.

## Test plan
- Single request: NREQ=4, req=0001, len0=5 → gnt=0001 for 6 cycles, then done=0001 for 1 cycle, busy follows gnt, err=0.
- Round-robin: req=1111 held and re-raised after each done, all len=2 → grant order 0,1,2,3,0, each grant 3 cycles, 1 idle cycle between grants.
- Zero and max length: len1=0 → gnt=0010 for 1 cycle then done. len2=2^19-1 (CBITS=19) → done after exactly 524288 gnt cycles, no wrap.
- Abort and latch: grant req0 with len0=10; change len0 to 3 mid-count (no effect, still 11 gnt cycles). Then drop req0 at cnt=4 → gnt=0 next cycle, no done; pending req2 is granted on the following edge.
- Reset mid-count: rst pulsed at cnt=7 → all outputs 0 and ptr=0 after the edge. Afterwards req=0110 grants requester 1 first.
- Checker: with DELAY_SCHED_CHK_EN, force cnt>lim in COUNT → err=1 next cycle and stays 1 until rst. Without the macro, err stays 0.

Source files
------------

// File: rtl/delay_sched.sv
// Round-robin scheduler sharing one CBITS-wide delay counter among NREQ requesters.
// Optional consistency checker driving err is enabled by defining DELAY_SCHED_CHK_EN.
module delay_sched #(
    parameter int NREQ  = 4,
    parameter int CBITS = 19
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*CBITS-1:0] len,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic                  busy,
    output logic                  err
);

    localparam int PW    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int SUM_W = PW + 1;

    typedef enum logic {
        IDLE,
        COUNT
    } state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic              busy_q, busy_d;
    logic [CBITS-1:0]  cnt_q, cnt_d;
    logic [CBITS-1:0]  lim_q, lim_d;
    logic [PW-1:0]     ptr_q, ptr_d;

    logic [CBITS-1:0]  len_arr [NREQ];
    logic [NREQ-1:0]   eligible;
    logic [2*NREQ-1:0] elig_rot;
    logic [PW-1:0]     win_off;
    logic [SUM_W-1:0]  win_sum;
    logic [SUM_W-1:0]  nxt_sum;
    logic [PW-1:0]     win;
    logic [PW-1:0]     ptr_nxt;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_len
            assign len_arr[gi] = len[gi*CBITS +: CBITS];
        end
    endgenerate

    // The requester finishing this cycle must not be re-granted straight away.
    assign eligible = req & ~done_q;
    assign elig_rot = {eligible, eligible} >> ptr_q;

    // Lowest set bit of the rotated vector is the offset of the winner from ptr.
    always_comb begin
        win_off = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (elig_rot[k]) begin
                win_off = PW'(k);
            end
        end
        win_sum = {1'b0, ptr_q} + {1'b0, win_off};
        if (win_sum >= SUM_W'(NREQ)) begin
            win_sum = win_sum - SUM_W'(NREQ);
        end
        win     = win_sum[PW-1:0];
        nxt_sum = {1'b0, win} + SUM_W'(1);
        if (nxt_sum >= SUM_W'(NREQ)) begin
            nxt_sum = '0;
        end
        ptr_nxt = nxt_sum[PW-1:0];
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        lim_d   = lim_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (|eligible) begin
                    gnt_d   = NREQ'(1) << win;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    lim_d   = len_arr[win];
                    ptr_d   = ptr_nxt;
                    state_d = COUNT;
                end
            end
            COUNT: begin
                if (~|(req & gnt_q)) begin
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (cnt_q == lim_q) begin
                    done_d  = gnt_q;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CBITS'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            lim_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            lim_q   <= lim_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef DELAY_SCHED_CHK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if ((state_q == COUNT) && (cnt_q > lim_q)) begin
            err_d = 1'b1;
        end
        if ((gnt_q & (gnt_q - NREQ'(1))) != '0) begin
            err_d = 1'b1;
        end
        if (busy_q != (|gnt_q)) begin
            err_d = 1'b1;
        end
        if ((done_q & (done_q - NREQ'(1))) != '0) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign gnt  = gnt_q;
    assign done = done_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_delay_sched.sv
// Directed bench for delay_sched: grant timing, round-robin order, abort, latching, reset, checker.
module tb_delay_sched;

    localparam int NREQ  = 4;
    localparam int CBITS = 19;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*CBITS-1:0] len;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic                  busy;
    logic                  err;

    // Narrow instance so the full-range length can be run end to end.
    logic [1:0]  req_s;
    logic [11:0] len_s;
    logic [1:0]  gnt_s;
    logic [1:0]  done_s;
    logic        busy_s;
    logic        err_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    delay_sched #(.NREQ(NREQ), .CBITS(CBITS)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .len  (len),
        .gnt  (gnt),
        .done (done),
        .busy (busy),
        .err  (err)
    );

    delay_sched #(.NREQ(2), .CBITS(6)) dut_s (
        .clk  (clk),
        .rst  (rst),
        .req  (req_s),
        .len  (len_s),
        .gnt  (gnt_s),
        .done (done_s),
        .busy (busy_s),
        .err  (err_s)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_len(input int i, input int v);
        len[i*CBITS +: CBITS] = CBITS'(v);
    endtask

    // Grant edge is the next edge; gnt for n+1 cycles, then one done cycle.
    task automatic expect_grant(input int w, input int n, input string tag);
        for (int k = 0; k <= n; k++) begin
            step();
            chk({tag, "_gnt"}, 32'(gnt), 32'(1) << w);
            chk({tag, "_busy"}, 32'(busy), 32'd1);
        end
        step();
        chk({tag, "_done"}, 32'(done), 32'(1) << w);
        chk({tag, "_gnt0"}, 32'(gnt), 32'd0);
        chk({tag, "_busy0"}, 32'(busy), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        $display("grant to %0d len %0d (%s) complete", w, n, tag);
    endtask

    task automatic idle();
        req = '0;
        step();
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_gnt", 32'(gnt), 32'd0);
    endtask

    initial begin
        rst   = 1'b1;
        req   = '0;
        len   = '0;
        req_s = '0;
        len_s = '0;
        step();
        step();
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        step();
        chk("rst_idle_gnt", 32'(gnt), 32'd0);

        // Round-robin with all requests held
        for (int i = 0; i < NREQ; i++) set_len(i, 2);
        req = 4'b1111;
        expect_grant(0, 2, "rr0");
        expect_grant(1, 2, "rr1");
        expect_grant(2, 2, "rr2");
        expect_grant(3, 2, "rr3");
        expect_grant(0, 2, "rr4");
        idle();

        // Single request
        set_len(0, 5);
        req = 4'b0001;
        expect_grant(0, 5, "single");
        idle();

        // Zero length
        set_len(1, 0);
        req = 4'b0010;
        expect_grant(1, 0, "zero");
        idle();

        // Length latched at grant
        set_len(0, 10);
        req = 4'b0001;
        step();
        chk("latch_gnt_first", 32'(gnt), 32'd1);
        set_len(0, 3);
        for (int k = 0; k < 10; k++) begin
            step();
            chk("latch_gnt", 32'(gnt), 32'd1);
        end
        step();
        chk("latch_done", 32'(done), 32'd1);
        idle();

        // Abort at cnt=4 with requester 2 pending
        set_len(0, 10);
        req = 4'b0001;
        step();
        chk("abort_gnt_first", 32'(gnt), 32'd1);
        req[2] = 1'b1;
        set_len(2, 1);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("abort_gnt_hold", 32'(gnt), 32'd1);
        end
        req[0] = 1'b0;
        step();
        chk("abort_gnt", 32'(gnt), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_nodone", 32'(done), 32'd0);
        expect_grant(2, 1, "after_abort");
        idle();

        // Reset mid-count at cnt=7
        set_len(0, 20);
        req = 4'b0001;
        step();
        chk("rmid_gnt", 32'(gnt), 32'd1);
        for (int k = 0; k < 7; k++) step();
        rst = 1'b1;
        step();
        chk("rmid_gnt0", 32'(gnt), 32'd0);
        chk("rmid_busy0", 32'(busy), 32'd0);
        chk("rmid_done0", 32'(done), 32'd0);
        chk("rmid_err0", 32'(err), 32'd0);
        chk("rmid_ptr0", 32'(dut.ptr_q), 32'd0);
        rst = 1'b0;
        req = 4'b0110;
        set_len(1, 3);
        expect_grant(1, 3, "post_rst");
        idle();

        // Consistency checker
`ifdef DELAY_SCHED_CHK_EN
        set_len(0, 5);
        req = 4'b0001;
        step();
        chk("chk_gnt", 32'(gnt), 32'd1);
        force dut.cnt_q = CBITS'(6);
        step();
        chk("chk_err_set", 32'(err), 32'd1);
        release dut.cnt_q;
        req = '0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("chk_err_sticky", 32'(err), 32'd1);
        end
        rst = 1'b1;
        step();
        chk("chk_err_clr", 32'(err), 32'd0);
        rst = 1'b0;
        step();
`else
        set_len(0, 5);
        req = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("nochk_err", 32'(err), 32'd0);
        end
        idle();
        step();
        chk("nochk_err_end", 32'(err), 32'd0);
`endif

        // Maximum length on the narrow instance: 64 grant cycles, no wrap
        len_s[5:0] = 6'd63;
        req_s      = 2'b01;
        for (int k = 0; k < 64; k++) begin
            step();
            chk("max_gnt", 32'(gnt_s), 32'd1);
        end
        step();
        chk("max_done", 32'(done_s), 32'd1);
        chk("max_gnt0", 32'(gnt_s), 32'd0);
        req_s = '0;
        step();
        chk("max_done_clr", 32'(done_s), 32'd0);
        $display("max length grant complete");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
